// File: rtl/pc_trace_pkg.sv
// Shared types and constants for the PC trace UART stage.
package pc_trace_pkg;

    // Record FSM states
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHAR,
        WAIT
    } rec_state_e;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A_OFF = 8'h37;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Eight hex digits followed by CR LF
    localparam int unsigned REC_CHARS = 10;

    // Uppercase ASCII for one hex nibble
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASCII_0 + {4'h0, n};
        end
        return ASCII_A_OFF + {4'h0, n};
    endfunction

    // Character at a given record index; rec is already shifted so the
    // digit to send sits in the top nibble
    function automatic logic [7:0] char_sel(input logic [3:0] idx, input logic [31:0] rec);
        if (idx < 4'd8) begin
            return hex_ascii(rec[31:28]);
        end else if (idx == 4'd8) begin
            return ASCII_CR;
        end
        return ASCII_LF;
    endfunction

endpackage

// File: rtl/pc_trace_uart_if.sv
// Core-facing signal bundle of the PC trace stage.
interface pc_trace_uart_if;
    logic [31:0] PC_IN;
    logic        EN;
    logic        TXD;
    logic        BUSY;
    logic        OVERFLOW;
    logic [15:0] DROP_CNT;

    // Board/core side: supplies the PC, observes the trace outputs
    modport master (
        output PC_IN,
        output EN,
        input  TXD,
        input  BUSY,
        input  OVERFLOW,
        input  DROP_CNT
    );

    // Trace stage side
    modport slave (
        input  PC_IN,
        input  EN,
        output TXD,
        output BUSY,
        output OVERFLOW,
        output DROP_CNT
    );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter, LSB first, idle high. done pulses during the
// last cycle of the stop bit so a follower can restart with no gap.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RST_X,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       done
);
    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(CLKS_PER_BIT - 1);

    logic          busy_q;
    logic [3:0]    bit_q;   // 0 start, 1..8 data, 9 stop
    logic [CW-1:0] cnt_q;
    logic [7:0]    shreg_q;
    logic          txd_q;

    // Bit sequencer: each bit held CLKS_PER_BIT cycles by the down-counter
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            busy_q  <= 1'b0;
            bit_q   <= 4'd0;
            cnt_q   <= '0;
            shreg_q <= 8'h00;
            txd_q   <= 1'b1;
        end else if (!busy_q) begin
            if (start) begin
                busy_q  <= 1'b1;
                bit_q   <= 4'd0;
                cnt_q   <= CNT_TOP;
                shreg_q <= data;
                txd_q   <= 1'b0;
            end
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end else begin
            cnt_q <= CNT_TOP;
            if (bit_q == 4'd9) begin
                busy_q <= 1'b0;
                txd_q  <= 1'b1;
            end else begin
                bit_q <= bit_q + 4'd1;
                if (bit_q == 4'd8) begin
                    txd_q <= 1'b1;
                end else begin
                    txd_q   <= shreg_q[0];
                    shreg_q <= {1'b0, shreg_q[7:1]};
                end
            end
        end
    end

    assign txd  = txd_q;
    assign done = busy_q && (bit_q == 4'd9) && (cnt_q == '0);

endmodule

// File: rtl/pc_trace_uart.sv
// PC trace stage: captures every PC change into a small FIFO and streams
// each entry as eight uppercase hex digits plus CR LF over UART.
module pc_trace_uart
    import pc_trace_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_AW      = 4
) (
    input logic        CLK,
    input logic        RST_X,
    pc_trace_uart_if.slave bus
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [31:0]      fifo_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q;
    logic [FIFO_AW:0] rd_ptr_q;
    logic [31:0]      last_pc_q;
    logic             overflow_q;
    logic [15:0]      drop_cnt_q;

    rec_state_e  state_q;
    logic [31:0] rec_q;
    logic [3:0]  idx_q;
    logic [7:0]  byte_q;
    logic        start_q;

    logic empty;
    logic full;
    logic capture;
    logic pop;
    logic push;
    logic drop;
    logic tx_done;
    logic tx_line;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

    assign capture = bus.EN && (bus.PC_IN != last_pc_q);
    // Pop only happens from IDLE with data present, so a full FIFO popping
    // in the same cycle always has room for the push.
    assign pop  = (state_q == IDLE) && !empty;
    assign push = capture && (!full || pop);
    assign drop = capture && full && !pop;

    // FIFO storage; no reset needed since the pointers define validity
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_q[wr_ptr_q[FIFO_AW-1:0]] <= bus.PC_IN;
        end
    end

    // Capture tracking, FIFO pointers and drop accounting
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_pc_q  <= 32'hFFFF_FFFF;
            overflow_q <= 1'b0;
            drop_cnt_q <= 16'h0000;
        end else begin
            // last_pc follows the PC even when the entry is dropped
            if (capture) begin
                last_pc_q <= bus.PC_IN;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'h0001;
                end
            end
        end
    end

    // Record FSM: pop, pick each character, kick the serializer, wait
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= IDLE;
            rec_q   <= 32'h0;
            idx_q   <= 4'd0;
            byte_q  <= 8'h00;
            start_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    start_q <= 1'b0;
                    if (!empty) begin
                        rec_q   <= fifo_q[rd_ptr_q[FIFO_AW-1:0]];
                        idx_q   <= 4'd0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    byte_q  <= char_sel(idx_q, rec_q);
                    state_q <= CHAR;
                end
                CHAR: begin
                    start_q <= 1'b1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    start_q <= 1'b0;
                    if (tx_done) begin
                        if (idx_q == 4'(REC_CHARS - 1)) begin
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            rec_q   <= {rec_q[27:0], 4'h0};
                            byte_q  <= char_sel(idx_q + 4'd1, {rec_q[27:0], 4'h0});
                            state_q <= CHAR;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .CLK  (CLK),
        .RST_X(RST_X),
        .start(start_q),
        .data (byte_q),
        .txd  (tx_line),
        .done (tx_done)
    );

    assign bus.TXD      = tx_line;
    assign bus.BUSY     = !empty || (state_q != IDLE);
    assign bus.OVERFLOW = overflow_q;
    assign bus.DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_pc_trace_uart.sv
// Bench for pc_trace_uart: transaction-level model with per-cycle output
// checks, a UART decoder, and literal expectations per scenario.
module tb_pc_trace_uart;
    localparam int unsigned C      = 4;
    localparam int unsigned AW     = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int         CHAR_T = 10 * C + 2;    // start-to-start of chars
    localparam int         REC_T  = 100 * C + 22;  // pop-to-pop of records

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pc_trace_uart_if bus();

    pc_trace_uart #(
        .CLKS_PER_BIT(C),
        .FIFO_AW     (AW)
    ) dut (
        .CLK  (clk),
        .RST_X(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [31:0] m_q[$];
    logic [31:0] m_last;
    logic        m_ovf;
    logic [15:0] m_drop;
    bit          m_act;
    int          m_k;
    int          m_e;
    logic [31:0] m_rec;

    function automatic logic [7:0] rec_char(input logic [31:0] rec, input int j);
        string hexd;
        logic [3:0] nib;
        hexd = "0123456789ABCDEF";
        if (j < 8) begin
            nib = rec[31 - 4 * j -: 4];
            return hexd[nib];
        end else if (j == 8) begin
            return 8'h0D;
        end
        return 8'h0A;
    endfunction

    function automatic logic exp_txd(input bit act, input int k, input int e,
                                     input logic [31:0] rec);
        int t, u, j, w, b;
        logic [7:0] ch;
        if (!act) return 1'b1;
        t = k - e;
        if (t < 3) return 1'b1;
        u = t - 3;
        j = u / CHAR_T;
        w = u % CHAR_T;
        if (j >= 10 || w >= 10 * C) return 1'b1;
        b = w / C;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        ch = rec_char(rec, j);
        return ch[b - 1];
    endfunction

    function automatic logic model_busy();
        return (m_q.size() > 0) || (m_act && (m_k < m_e + REC_T - 1));
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_last = 32'hFFFF_FFFF;
                m_ovf  = 1'b0;
                m_drop = 16'h0;
                m_act  = 1'b0;
                m_k    = 0;
                m_e    = 0;
                m_rec  = 32'h0;
            end else begin
                m_k++;
                if ((!m_act || m_k >= m_e + REC_T) && m_q.size() > 0) begin
                    m_rec = m_q.pop_front();
                    m_act = 1'b1;
                    m_e   = m_k;
                end
                if (bus.EN && bus.PC_IN != m_last) begin
                    m_last = bus.PC_IN;
                    if (m_q.size() < DEPTH) begin
                        m_q.push_back(bus.PC_IN);
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drop != 16'hFFFF) m_drop++;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            check("txd", bus.TXD, exp_txd(m_act, m_k, m_e, m_rec));
            check("busy", bus.BUSY, model_busy());
            check("overflow", bus.OVERFLOW, m_ovf);
            check("drop_cnt", bus.DROP_CNT, m_drop);
        end
    end

    // ---------------- UART decoder ----------------
    logic [7:0] rx_q[$];
    bit         d_act = 1'b0;
    int         d_cnt = 0;
    logic [7:0] d_byte;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                d_act = 1'b0;
            end else if (!d_act) begin
                if (bus.TXD === 1'b0) begin
                    d_act = 1'b1;
                    d_cnt = 0;
                end
            end else begin
                d_cnt++;
                if (d_cnt % C == C / 2 && d_cnt / C >= 1 && d_cnt / C <= 8) begin
                    d_byte[d_cnt / C - 1] = bus.TXD;
                end
                if (d_cnt == 9 * C + C / 2) begin
                    check("stop_bit", bus.TXD, 1'b1);
                    rx_q.push_back(d_byte);
                    d_act = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done_ok;
        done_ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (!model_busy()) begin
                done_ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", done_ok, 1'b1);
        repeat (20) tick();
        check("busy_after_drain", bus.BUSY, 1'b0);
    endtask

    task automatic check_rx(input string name, input string exp);
        int n;
        check({name, "_len"}, rx_q.size(), exp.len());
        n = (rx_q.size() < exp.len()) ? rx_q.size() : exp.len();
        for (int i = 0; i < n; i++) begin
            check({name, "_char"}, rx_q[i], exp[i]);
        end
        rx_q.delete();
    endtask

    task automatic wait_model(input int target_off, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (m_act && (m_k == m_e + target_off)) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check(name, hit, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.PC_IN = 32'h0;
        bus.EN    = 1'b0;
        rst_n     = 1'b0;
        repeat (3) tick();
        check("rst_txd", bus.TXD, 1'b1);
        check("rst_busy", bus.BUSY, 1'b0);
        check("rst_overflow", bus.OVERFLOW, 1'b0);
        check("rst_drop_cnt", bus.DROP_CNT, 16'h0);
        rst_n = 1'b1;
        tick();

        // 1: first PC after reset, even zero, is captured
        bus.EN    = 1'b1;
        bus.PC_IN = 32'h0000_0000;
        drain();
        check_rx("t1", "00000000\015\012");

        // 2: a stable value produces one record only
        bus.PC_IN = 32'hDEAD_BEEF;
        repeat (1000) tick();
        drain();
        check_rx("t2", "DEADBEEF\015\012");

        // 4: capture disabled, then re-enabled
        bus.EN = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.PC_IN = 32'(i * 16);
            repeat (3) tick();
        end
        repeat (20) tick();
        check("t4_busy", bus.BUSY, 1'b0);
        check("t4_no_rx", rx_q.size(), 0);
        bus.PC_IN = 32'h1234_5678;
        bus.EN    = 1'b1;
        drain();
        check_rx("t4", "12345678\015\012");

        // 3: one change per cycle overruns the depth-4 FIFO
        for (int i = 0; i < 8; i++) begin
            bus.PC_IN = 32'(i * 4);
            tick();
        end
        check("t3_overflow", bus.OVERFLOW, 1'b1);
        check("t3_drop_cnt", bus.DROP_CNT, 16'd3);

        // 6: push lands on the same edge as a pop from a full FIFO
        wait_model(REC_T - 1, "t6_wait");
        bus.PC_IN = 32'h0000_0020;
        tick();
        check("t6_drop_cnt", bus.DROP_CNT, 16'd3);
        check("t6_busy", bus.BUSY, 1'b1);
        drain();
        check_rx("t3_t6", {"00000000\015\012", "00000004\015\012", "00000008\015\012",
                           "0000000C\015\012", "00000010\015\012", "00000020\015\012"});
        check("t6_drop_final", bus.DROP_CNT, 16'd3);
        check("t6_overflow_final", bus.OVERFLOW, 1'b1);

        // 5: reset during the start bit of the 4th character
        bus.PC_IN = 32'hCAFE_F00D;
        wait_model(3 + 3 * CHAR_T + 1, "t5_wait");
        check("t5_pre_txd", bus.TXD, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_txd", bus.TXD, 1'b1);
        check("t5_busy", bus.BUSY, 1'b0);
        check("t5_overflow", bus.OVERFLOW, 1'b0);
        check("t5_drop_cnt", bus.DROP_CNT, 16'h0);
        bus.PC_IN = 32'h0BAD_C0DE;
        repeat (3) tick();
        rst_n = 1'b1;
        rx_q.delete();
        drain();
        check_rx("t5", "0BADC0DE\015\012");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_trace_uart.md
# pc_trace_uart

Debug stage directly downstream of the core's `PCout`. It records every change of the program counter into a small FIFO and streams each entry over a UART TX line as 8 uppercase hex ASCII characters followed by CR LF. The stage is instantiated next to `main` in the board top and shares its clock `CLK` and reset `RST_X`. It exists for bring-up: watching execution flow on a serial terminal without a logic analyser.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 2.
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW entries.

Ports:
- `CLK` in 1: the single clock for the block.
- `RST_X` in 1: reset, asynchronous, active-low.
- `PC_IN` in 32: program counter from the core (`PCout`).
- `EN` in 1: capture enable; when low, no new entries are captured, but queued entries still drain.
- `TXD` out 1: UART serial output, 8N1, LSB first, idle high.
- `BUSY` out 1: high while the FIFO is non-empty or a record is being transmitted.
- `OVERFLOW` out 1: sticky; set on the first dropped capture; cleared only by reset.
- `DROP_CNT` out 16: count of dropped captures; saturates at 0xFFFF.

## Operation
- Reset values:
  - `TXD`=1, `BUSY`=0, `OVERFLOW`=0, `DROP_CNT`=0.
  - FIFO empty.
  - `last_pc`=0xFFFFFFFF, so the first real PC is always captured.
- Capture condition: `EN`=1 and `PC_IN`≠`last_pc`.
  - On capture, `last_pc`←`PC_IN` and a push is requested.
  - `last_pc` updates even when the push is dropped.
- Push and pop rules:
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped: `OVERFLOW`←1 and `DROP_CNT` increments, saturating.
  - Simultaneous push and pop on an empty FIFO: the push is accepted; the pop does not occur because the FIFO was empty.
- Record FSM states: `IDLE`, `LOAD`, `CHAR`, `WAIT`.
  - `IDLE`→`LOAD` when the FIFO is non-empty. This cycle pops the head into a 32-bit shift register `rec` and clears the char index to 0.
  - `LOAD`→`CHAR`: selects the char.
    - Index 0..7: nibble `rec[31:28]` shifted left by 4 per char; 0–9 → 0x30+n, A–F → 0x37+n.
    - Index 8 = 0x0D; index 9 = 0x0A.
  - `CHAR`→`WAIT`: the byte is handed to the serializer with a one-cycle `start` pulse.
  - `WAIT`→`CHAR` when the serializer's `done` is asserted and index<9; the index increments.
  - `WAIT`→`IDLE` when `done` is asserted and index=9.
- Serializer:
  - Frame: start bit (0), 8 data bits LSB first, stop bit (1).
  - Each bit is held exactly `CLKS_PER_BIT` cycles by a down-counter.
  - `done` pulses one cycle at the end of the stop bit.
- `BUSY` = FIFO non-empty OR FSM≠`IDLE`.
- Reset asserted mid-record: all state is cleared immediately; `TXD` returns high asynchronously. A truncated frame on the line is acceptable.

## Timing
- Capture: `PC_IN` sampled at edge N; entry visible in the FIFO after edge N; earliest pop at edge N+1.
- `TXD` start bit falls 3 cycles after the pop edge (`LOAD`, `CHAR`, serializer start).
- Per char: 10·`CLKS_PER_BIT` cycles plus 2 cycles of FSM overhead (`WAIT`→`CHAR`→start).
- Per record: 10 chars, about 100·`CLKS_PER_BIT` cycles.
- Sustained capture rate: one PC change per record time, before drops begin.
- `OVERFLOW` and `DROP_CNT` update on the edge where the push is refused.

## Structure
- Shared package `pc_trace_pkg`:
  - FSM state encoding (`IDLE`/`LOAD`/`CHAR`/`WAIT`).
  - ASCII constants: `ASCII_0`=0x30, `ASCII_A_OFF`=0x37, `ASCII_CR`=0x0D, `ASCII_LF`=0x0A.
  - Record length constant `REC_CHARS`=10.
- Sub-module `uart_tx_byte` (ports `CLK`, `RST_X`, `start`, `data[7:0]`, `txd`, `done`; parameter `CLKS_PER_BIT`).
  - Reusable for later UART debug ports.
- FIFO is inline: registers, plus read/write pointers of `FIFO_AW`+1 bits; full/empty come from comparing the pointers' MSB.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_AW`=2 (depth 4).
1. Reset, then `PC_IN`=0x00000000 with `EN`=1 → one record; UART-decoded bytes are "00000000\r\n"; `BUSY` drops after the LF stop bit.
2. `PC_IN`=0xDEADBEEF held for 1000 cycles → exactly one record, "DEADBEEF\r\n"; no repeats while the value is stable.
3. `PC_IN` stepping 0x0,0x4,0x8,… one per cycle for 8 cycles:
   - 4 entries queued plus 1 in flight are transmitted in order.
   - `OVERFLOW`=1 and `DROP_CNT`=3.
4. `EN`=0 while `PC_IN` changes → no records; `BUSY`=0. Then `EN`=1 with value 0x12345678 → "12345678\r\n".
5. Assert `RST_X` low during the 4th char → `TXD`=1 immediately; all outputs at their reset values. After release, a new PC is transmitted cleanly.
6. Push and pop in the same cycle with the FIFO full → push accepted; `DROP_CNT` unchanged; order preserved in the decoded stream.
